// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a one-entry skid buffer; optional perf counters under EX_MEM_PERF_CNT_EN.
// Latency: 1 cycle from ex_valid to me_valid; one transfer per cycle when me_ready is held high.
// Backpressure: a stalled main entry diverts one input into skid; ex_ready is a flop (!skid_valid).
module ex_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int MAT_W  = 128,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_regs_data2,
  input  logic [DATA_W-1:0] ex_alu_o,
  input  logic [MAT_W-1:0]  ex_matrix_o,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic [RD_W-1:0]   ex_rs2,
  input  logic              ex_mem_read,
  input  logic              ex_mem2reg,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_w_select,
  input  logic              ex_rs2_r_select,
  input  logic [2:0]        ex_func3_code,
  output logic              me_valid,
  input  logic              me_ready,
  output logic [DATA_W-1:0] me_regs_data2,
  output logic [DATA_W-1:0] me_alu_o,
  output logic [MAT_W-1:0]  me_matrix_o,
  output logic [RD_W-1:0]   me_rd,
  output logic [RD_W-1:0]   me_rs2,
  output logic              me_mem_read,
  output logic              me_mem2reg,
  output logic              me_mem_write,
  output logic [1:0]        me_w_select,
  output logic              me_rs2_r_select,
  output logic [2:0]        me_func3_code,
  output logic [RD_W-1:0]   me_fwd_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int PW = 2*DATA_W + MAT_W + 2*RD_W + 9;

  logic [PW-1:0] in_dat;
  logic [PW-1:0] m_dat;
  logic [PW-1:0] s_dat;
  logic          m_valid;
  logic          s_valid;
  logic          accept;
  logic          m_mem_read;
  logic          m_mem2reg;
  logic          m_mem_write;
  logic [1:0]    m_w_select;

  assign in_dat = {ex_regs_data2, ex_alu_o, ex_matrix_o, ex_rd, ex_rs2, ex_mem_read,
                   ex_mem2reg, ex_mem_write, ex_w_select, ex_rs2_r_select, ex_func3_code};
  assign accept = ex_valid && ex_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid  <= 1'b0;
      s_valid  <= 1'b0;
      ex_ready <= 1'b1;
      m_dat    <= '0;
      s_dat    <= '0;
    end else if (flush) begin
      m_valid  <= 1'b0;
      s_valid  <= 1'b0;
      ex_ready <= 1'b1;
    end else if (!m_valid || me_ready) begin
      // Main slot frees up this cycle: skid entry has priority (ex_ready is low while it is held).
      if (s_valid) begin
        m_dat    <= s_dat;
        m_valid  <= 1'b1;
        s_valid  <= 1'b0;
        ex_ready <= 1'b1;
      end else begin
        m_valid <= accept;
        if (accept) m_dat <= in_dat;
      end
    end else if (accept) begin
      s_dat    <= in_dat;
      s_valid  <= 1'b1;
      ex_ready <= 1'b0;
    end
  end

  assign {me_regs_data2, me_alu_o, me_matrix_o, me_rd, me_rs2, m_mem_read, m_mem2reg,
          m_mem_write, m_w_select, me_rs2_r_select, me_func3_code} = m_dat;

  assign me_valid     = m_valid;
  assign me_mem_read  = m_valid & m_mem_read;
  assign me_mem2reg   = m_valid & m_mem2reg;
  assign me_mem_write = m_valid & m_mem_write;
  assign me_w_select  = m_valid ? m_w_select : 2'b00;
  assign me_fwd_rd    = m_valid ? me_rd : '0;

`ifdef EX_MEM_PERF_CNT_EN
  // Saturating counters: stop at all-ones rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (m_valid && !me_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (m_valid || s_valid) && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg (MAT_W=256, CNT_W=4); counter expectations follow EX_MEM_PERF_CNT_EN.
module tb_ex_mem_skid_reg;
  localparam int DATA_W = 32;
  localparam int MAT_W  = 256;
  localparam int RD_W   = 5;
  localparam int CNT_W  = 4;

`ifdef EX_MEM_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_regs_data2, ex_alu_o;
  logic [MAT_W-1:0]  ex_matrix_o;
  logic [RD_W-1:0]   ex_rd, ex_rs2;
  logic              ex_mem_read, ex_mem2reg, ex_mem_write;
  logic [1:0]        ex_w_select;
  logic              ex_rs2_r_select;
  logic [2:0]        ex_func3_code;
  logic              me_valid;
  logic              me_ready;
  logic [DATA_W-1:0] me_regs_data2, me_alu_o;
  logic [MAT_W-1:0]  me_matrix_o;
  logic [RD_W-1:0]   me_rd, me_rs2;
  logic              me_mem_read, me_mem2reg, me_mem_write;
  logic [1:0]        me_w_select;
  logic              me_rs2_r_select;
  logic [2:0]        me_func3_code;
  logic [RD_W-1:0]   me_fwd_rd;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_err = 0;

  logic [MAT_W-1:0] mat_pat;

  ex_mem_skid_reg #(.DATA_W(DATA_W), .MAT_W(MAT_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_regs_data2(ex_regs_data2), .ex_alu_o(ex_alu_o), .ex_matrix_o(ex_matrix_o),
    .ex_rd(ex_rd), .ex_rs2(ex_rs2), .ex_mem_read(ex_mem_read), .ex_mem2reg(ex_mem2reg),
    .ex_mem_write(ex_mem_write), .ex_w_select(ex_w_select), .ex_rs2_r_select(ex_rs2_r_select),
    .ex_func3_code(ex_func3_code),
    .me_valid(me_valid), .me_ready(me_ready),
    .me_regs_data2(me_regs_data2), .me_alu_o(me_alu_o), .me_matrix_o(me_matrix_o),
    .me_rd(me_rd), .me_rs2(me_rs2), .me_mem_read(me_mem_read), .me_mem2reg(me_mem2reg),
    .me_mem_write(me_mem_write), .me_w_select(me_w_select), .me_rs2_r_select(me_rs2_r_select),
    .me_func3_code(me_func3_code), .me_fwd_rd(me_fwd_rd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] perf(input int v);
    return PERF ? CNT_W'(v) : '0;
  endfunction

  initial begin
    mat_pat = '0;
    mat_pat[MAT_W-1:MAT_W/2] = '1;
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; me_ready = 1'b0;
    ex_regs_data2 = 32'h1234_5678; ex_alu_o = '0; ex_matrix_o = '0;
    ex_rd = '0; ex_rs2 = 5'd9; ex_mem_read = 1'b0; ex_mem2reg = 1'b0; ex_mem_write = 1'b0;
    ex_w_select = 2'b00; ex_rs2_r_select = 1'b0; ex_func3_code = 3'd0;
    #3;
    check("rst_me_valid", me_valid, 0);
    check("rst_ex_ready", ex_ready, 1);
    check("rst_me_alu_o", me_alu_o, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    #9 rst = 1'b0;
    tick();

    // Streaming with me_ready held high
    me_ready = 1'b1; ex_valid = 1'b1; ex_rd = 5'd3; ex_mem_write = 1'b1; ex_w_select = 2'b10;
    ex_func3_code = 3'd5;
    for (int i = 0; i < 3; i++) begin
      ex_alu_o = 32'h10 + 32'(i);
      tick();
      check("stream_me_valid", me_valid, 1);
      check("stream_me_alu_o", me_alu_o, 32'h10 + 32'(i));
      check("stream_ex_ready", ex_ready, 1);
    end
    check("stream_fwd_rd", me_fwd_rd, 3);
    check("stream_mem_write", me_mem_write, 1);
    check("stream_w_select", me_w_select, 2);
    check("stream_func3", me_func3_code, 5);
    check("stream_rs2", me_rs2, 9);
    ex_valid = 1'b0;
    tick();
    check("drain_me_valid", me_valid, 0);
    check("drain_fwd_rd", me_fwd_rd, 0);
    check("drain_mem_write", me_mem_write, 0);
    check("drain_w_select", me_w_select, 0);
    check("drain_alu_unqual", me_alu_o, 32'h12);
    check("drain_rd_unqual", me_rd, 3);

    // Backpressure: 0xA fills M, 0xB lands in skid
    me_ready = 1'b0; ex_valid = 1'b1; ex_alu_o = 32'hA;
    tick();
    check("bp_m_alu", me_alu_o, 32'hA);
    check("bp_ready_after_m", ex_ready, 1);
    ex_alu_o = 32'hB;
    tick();
    check("bp_hold_alu", me_alu_o, 32'hA);
    check("bp_ready_low", ex_ready, 0);
    check("bp_stall1", stall_cnt, perf(1));
    ex_valid = 1'b0;
    tick();
    check("bp_stable_valid", me_valid, 1);
    check("bp_stable_alu", me_alu_o, 32'hA);
    check("bp_stall2", stall_cnt, perf(2));
    me_ready = 1'b1;
    tick();
    check("bp_skid_to_m", me_alu_o, 32'hB);
    check("bp_skid_valid", me_valid, 1);
    check("bp_ready_back", ex_ready, 1);
    tick();
    check("bp_empty", me_valid, 0);
    check("bp_stall_held", stall_cnt, perf(2));

    // Flush with both entries full and an input offered
    me_ready = 1'b0; ex_valid = 1'b1; ex_rd = 5'd7; ex_mem_write = 1'b1; ex_alu_o = 32'h20;
    tick();
    ex_alu_o = 32'h21;
    tick();
    check("fl_ready_low", ex_ready, 0);
    check("fl_stall3", stall_cnt, perf(3));
    flush = 1'b1;
    tick();
    check("fl_me_valid", me_valid, 0);
    check("fl_fwd_rd", me_fwd_rd, 0);
    check("fl_mem_write", me_mem_write, 0);
    check("fl_ex_ready", ex_ready, 1);
    check("fl_flush_cnt", flush_cnt, perf(1));
    check("fl_stall4", stall_cnt, perf(4));
    tick();
    check("fl_discard_accept", me_valid, 0);
    check("fl_cnt_empty", flush_cnt, perf(1));
    flush = 1'b0; ex_valid = 1'b0;
    tick();
    check("fl_idle", me_valid, 0);

    // Wide payload load, then stall into saturation
    ex_valid = 1'b1; ex_rd = 5'd5; ex_matrix_o = mat_pat;
    tick();
    ex_valid = 1'b0; ex_matrix_o = '0;
    check("wide_matrix", me_matrix_o, mat_pat);
    check("wide_fwd_rd", me_fwd_rd, 5);
    repeat (20) tick();
    check("sat_stall", stall_cnt, perf(15));
    repeat (2) tick();
    check("sat_stall_hold", stall_cnt, perf(15));
    check("sat_me_valid", me_valid, 1);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("arst_me_valid", me_valid, 0);
    check("arst_me_rd", me_rd, 0);
    check("arst_matrix", me_matrix_o, 0);
    check("arst_ex_ready", ex_ready, 1);
    check("arst_stall", stall_cnt, 0);
    check("arst_flush", flush_cnt, 0);
    #1 rst = 1'b0;

    // First edge after reset accepts
    me_ready = 1'b1; ex_valid = 1'b1; ex_alu_o = 32'h55; ex_matrix_o = mat_pat;
    tick();
    check("post_rst_valid", me_valid, 1);
    check("post_rst_alu", me_alu_o, 32'h55);
    check("post_rst_matrix", me_matrix_o, mat_pat);
    ex_valid = 1'b0;
    tick();
    check("post_rst_drain", me_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ex_mem_skid_reg.md
EX_MEM_SKID_REG -- requirements
Module: ex_mem_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning scalar data width of regs_data2 and alu_o.
REQ-002 SHALL have parameter MAT_W, default 128, meaning matrix result width; legal values are multiples of 32.
REQ-003 SHALL have parameter RD_W, default 5, meaning register index width of rd and rs2.
REQ-004 SHALL have parameter CNT_W, default 16, meaning performance counter width.
REQ-005 SHALL have port clk  in  1  meaning sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  meaning reset, asynchronous and active-high.
REQ-007 SHALL have port flush  in  1  meaning synchronous kill of all held entries.
REQ-008 SHALL have ports ex_valid in 1 and ex_ready out 1, forming the upstream handshake.
REQ-009 SHALL have the following EX payload inputs: ex_regs_data2[DATA_W], ex_alu_o[DATA_W], ex_matrix_o[MAT_W], ex_rd[RD_W], ex_rs2[RD_W], ex_mem_read, ex_mem2reg, ex_mem_write, ex_w_select[2], ex_rs2_r_select, ex_func3_code[3].
REQ-010 SHALL have ports me_valid out 1 and me_ready in 1, forming the downstream handshake.
REQ-011 SHALL have me_* outputs that mirror each ex_* payload input at the same width.
REQ-012 SHALL have port me_fwd_rd  out  RD_W  meaning forwarding destination register, qualified by valid.
REQ-013 SHALL have ports stall_cnt out CNT_W and flush_cnt out CNT_W, carrying the performance counters.

Function
REQ-014 SHALL hold two payload entries: main register M, which drives the me_* outputs, and skid register S.
REQ-015 SHALL accept an input on a cycle where ex_valid && ex_ready; a downstream transfer SHALL occur on a cycle where me_valid && me_ready.
REQ-016 SHALL drive ex_ready from a flop equal to !S_valid, so there is no combinational path from me_ready to ex_ready.
REQ-017 SHALL, on an accept while M is empty or M transfers out that cycle, load the input into M; latency is 1 cycle (ex_valid at edge N gives me_valid after edge N).
REQ-018 SHALL, on an accept while M is valid and me_ready=0, load the input into S and deassert ex_ready on the next cycle.
REQ-019 SHALL, on a transfer out of M while S is valid, move S into M and clear S, which reasserts ex_ready.
REQ-020 SHALL sustain one transfer per cycle when me_ready is held at 1.
REQ-021 SHALL hold M contents and me_valid stable while me_valid && !me_ready.
REQ-022 SHALL, when flush=1, clear M_valid and S_valid at the next edge, discard any input accepted that cycle, and give flush priority over every simultaneous accept or transfer; payload flops need not be cleared.
REQ-023 SHALL force me_mem_read, me_mem_write, me_mem2reg and me_w_select to 0 whenever me_valid=0.
REQ-024 SHALL drive me_fwd_rd as me_valid ? me_rd : 0.
REQ-025 SHALL pass every other me_* payload output unqualified from M.
REQ-026 SHALL keep state and outputs unchanged when ex_valid=0, me_valid=0 and flush=0.

Reset
REQ-027 SHALL, while rst=1 and independent of clk, set M_valid=0, S_valid=0, ex_ready=1, all me_* payload outputs to 0, and stall_cnt=flush_cnt=0.
REQ-028 SHALL discard any entry held when rst is asserted mid-operation, and SHALL accept input at the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro EX_MEM_PERF_CNT_EN defined, increment stall_cnt each cycle with me_valid && !me_ready and increment flush_cnt each cycle with flush=1 while M_valid or S_valid was 1; both counters saturate at 2^CNT_W-1 and never wrap.
REQ-030 SHALL, with EX_MEM_PERF_CNT_EN undefined, tie stall_cnt and flush_cnt to 0 and implement no counter flops; handshake and payload behaviour SHALL be identical with and without the macro.

Verification
REQ-031 SHALL cover streaming: me_ready=1 with ex_alu_o=0x10,0x11,0x12 on consecutive cycles -> me_alu_o shows 0x10,0x11,0x12 one cycle later each, ex_ready stays 1.
REQ-032 SHALL cover backpressure: me_ready=0 with ex_alu_o=0xA then 0xB -> M=0xA, S=0xB, ex_ready=0 next cycle; me_ready=1 -> 0xA then 0xB, ex_ready=1 after 0xB enters M.
REQ-033 SHALL cover flush: M and S both full and flush=1 with ex_valid=1 -> me_valid=0, me_fwd_rd=0, me_mem_write=0 next cycle, ex_ready=1, and flush_cnt=1 when the macro is defined.
REQ-034 SHALL cover mid-operation reset: rst asserted between edges with M valid and ex_rd=5 -> me_valid=0, me_rd=0 immediately, without waiting for a clock edge.
REQ-035 SHALL cover counter saturation: CNT_W=4 with 20 stall cycles -> stall_cnt=15, held at 15.
REQ-036 SHALL cover wide payload: MAT_W=256 with ex_matrix_o all-ones in the upper half and zero in the lower half -> me_matrix_o bit-exact after transfer.
